// File: rtl/fsm_tbl_pkg.sv
// Shared types and constants for the table-driven FSM scheduler.
// Latency: none (definitions only).
// Backpressure: n/a.
// Contents: controller states, table field widths, default table image
// and entry field accessors.
package fsm_tbl_pkg;

    localparam int ST_W   = 3;
    localparam int A_W    = 2;
    localparam int OUT_W  = 3;
    localparam int TBL_AW = ST_W + A_W;
    localparam int TBL_DW = ST_W + OUT_W;
    localparam int TBL_N  = 1 << TBL_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_OUT  = 2'd2
    } ctrl_state_t;

    typedef logic [TBL_DW-1:0] tbl_entry_t;

    // Entry = {next[2:0], saida[2:0]}, address = {state[2:0], a[1:0]}.
    localparam tbl_entry_t DEFAULT_TBL [TBL_N] = '{
        0:       6'h08,
        1:       6'h11,
        10:      6'h22,
        18:      6'h3a,
        default: 6'h00
    };

    function automatic logic [ST_W-1:0] ent_next(input tbl_entry_t e);
        return e[TBL_DW-1:OUT_W];
    endfunction

    function automatic logic [OUT_W-1:0] ent_out(input tbl_entry_t e);
        return e[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request after i_ptr, wrapping.
// Latency: combinational.
// Backpressure: none; grant is zero when no request is pending.
// Ports: i_req (NCH requests), i_ptr (last granted channel), o_gnt (one-hot grant).
module rr_arb #(
    parameter int NCH = 2,
    parameter int CW  = 1
) (
    input  logic [NCH-1:0] i_req,
    input  logic [CW-1:0]  i_ptr,
    output logic [NCH-1:0] o_gnt
);

    logic w_found;

    // k walks the search order ptr+1, ptr+2, ...; c is kept a loop constant
    // so every bit select is static.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!w_found && (((int'(i_ptr) + k) % NCH) == c) && i_req[c]) begin
                    o_gnt[c] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fsm_tbl_sched.sv
// Shares one 32x6 transition-table FSM engine between NCH channels, each with its own 3-bit state.
// Latency: grant in T, table step in T+1, o_out_valid from T+2; at most one transaction in flight.
// Backpressure: o_out_valid holds until i_out_ready; no grants (o_req_ready=0) until the result drains.
// Ports: i_req_valid/i_req_a/o_req_ready request side; o_out_* result side with i_out_ready;
//        i_cfg_we/i_cfg_addr/i_cfg_data table write (only taken in idle), o_cfg_busy; i_ctx_clr per-channel clear.
// Build option: define FSM_TBL_DEFAULT_EN to reset-load the table from DEFAULT_TBL; otherwise
//               the table is unreset memory that must be programmed before use.
module fsm_tbl_sched
    import fsm_tbl_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NCH-1:0]     i_req_valid,
    input  logic [2*NCH-1:0]   i_req_a,
    output logic [NCH-1:0]     o_req_ready,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [CW-1:0]      o_out_ch,
    output logic [OUT_W-1:0]   o_out_saida,
    output logic [ST_W-1:0]    o_out_state,
    input  logic               i_cfg_we,
    input  logic [TBL_AW-1:0]  i_cfg_addr,
    input  logic [TBL_DW-1:0]  i_cfg_data,
    output logic               o_cfg_busy,
    input  logic [NCH-1:0]     i_ctx_clr
);

    ctrl_state_t       r_state;
    logic [CW-1:0]     r_rr;
    logic [CW-1:0]     r_ch;
    logic [A_W-1:0]    r_a;
    logic [ST_W-1:0]   r_ctx [NCH];
    tbl_entry_t        r_tbl [TBL_N];
    logic              r_out_valid;
    logic [CW-1:0]     r_out_ch;
    logic [OUT_W-1:0]  r_out_saida;
    logic [ST_W-1:0]   r_out_state;

    logic [NCH-1:0]    w_gnt;
    logic [CW-1:0]     w_gnt_ch;
    logic [A_W-1:0]    w_gnt_a;
    logic              w_idle;
    logic              w_cfg_wr;
    logic [TBL_AW-1:0] w_lu_addr;
    tbl_entry_t        w_lu_dat;
    logic [ST_W-1:0]   w_lu_next;
    logic [OUT_W-1:0]  w_lu_out;

    rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
        .i_req (i_req_valid),
        .i_ptr (r_rr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_gnt_ch = '0;
        w_gnt_a  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_gnt[c]) begin
                w_gnt_ch = CW'(c);
                w_gnt_a  = i_req_a[2*c +: 2];
            end
        end
    end

    assign w_idle   = (r_state == S_IDLE);
    // A table write takes the idle cycle, so it also suppresses the grant.
    assign w_cfg_wr = w_idle && i_cfg_we;

    assign o_req_ready = (i_rst_n && w_idle && !i_cfg_we) ? w_gnt : '0;
    assign o_cfg_busy  = !w_idle;

    assign w_lu_addr = {r_ctx[r_ch], r_a};
    assign w_lu_dat  = r_tbl[w_lu_addr];
    assign w_lu_next = ent_next(w_lu_dat);
    assign w_lu_out  = ent_out(w_lu_dat);

    assign o_out_valid = r_out_valid;
    assign o_out_ch    = r_out_ch;
    assign o_out_saida = r_out_saida;
    assign o_out_state = r_out_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rr        <= CW'(NCH - 1);
            r_ch        <= '0;
            r_a         <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_saida <= '0;
            r_out_state <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_cfg_we && (|i_req_valid)) begin
                        r_ch    <= w_gnt_ch;
                        r_a     <= w_gnt_a;
                        r_rr    <= w_gnt_ch;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_out_ch    <= r_ch;
                    r_out_saida <= w_lu_out;
                    r_out_state <= w_lu_next;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Clear beats the writeback of the channel in flight; out_state
            // above still reports the looked-up next state.
            for (int i = 0; i < NCH; i++) begin
                if (i_ctx_clr[i]) begin
                    r_ctx[i] <= '0;
                end else if ((r_state == S_EXEC) && (r_ch == CW'(i))) begin
                    r_ctx[i] <= w_lu_next;
                end
            end
        end
    end

`ifdef FSM_TBL_DEFAULT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tbl <= DEFAULT_TBL;
        end else if (w_cfg_wr) begin
            r_tbl[i_cfg_addr] <= i_cfg_data;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (w_cfg_wr) begin
            r_tbl[i_cfg_addr] <= i_cfg_data;
        end
    end
`endif

endmodule

// File: tb/tb_fsm_tbl_sched.sv
module tb_fsm_tbl_sched;

    localparam int NCH = 2;
    localparam int CW  = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NCH-1:0]   req_valid = '0;
    logic [2*NCH-1:0] req_a = '0;
    logic [NCH-1:0]   req_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    out_ch;
    logic [2:0]       out_saida;
    logic [2:0]       out_state;
    logic             cfg_we = 1'b0;
    logic [4:0]       cfg_addr = '0;
    logic [5:0]       cfg_data = '0;
    logic             cfg_busy;
    logic [NCH-1:0]   ctx_clr = '0;

    always #5 clk = ~clk;

    fsm_tbl_sched #(.NCH(NCH), .CW(CW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .o_req_ready (req_ready),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_ch    (out_ch),
        .o_out_saida (out_saida),
        .o_out_state (out_state),
        .i_cfg_we    (cfg_we),
        .i_cfg_addr  (cfg_addr),
        .i_cfg_data  (cfg_data),
        .o_cfg_busy  (cfg_busy),
        .i_ctx_clr   (ctx_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: table image, per-channel state, last granted channel.
    logic [5:0]     m_tbl [32];
    logic [2:0]     m_ctx [NCH];
    int             m_rr;
    int             e_ch;
    logic [2:0]     e_out, e_next;
    logic [NCH-1:0] exp_rdy;

    // Observations captured by step().
    logic [NCH-1:0] o_rdy, o_rdy1;
    logic           o_busy1, o_vld1, o_vld2, o_busy_out, o_stable, o_busy3, o_vld3;
    logic [CW-1:0]  o_ch;
    logic [2:0]     o_saida, o_state;

    function automatic logic [5:0] spec_default(input int addr);
        case (addr)
            0:       return 6'h08;
            1:       return 6'h11;
            10:      return 6'h22;
            18:      return 6'h3a;
            default: return 6'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_rr = NCH - 1;
        for (int i = 0; i < NCH; i++) m_ctx[i] = 3'd0;
`ifdef FSM_TBL_DEFAULT_EN
        for (int i = 0; i < 32; i++) m_tbl[i] = spec_default(i);
`endif
    endtask

    // One accepted request: pick the channel, step its state, apply clears.
    task automatic m_txn(input logic [NCH-1:0] vld, input logic [2*NCH-1:0] a, input logic [NCH-1:0] clr);
        logic [1:0] sym;
        logic [5:0] ent;
        e_ch = -1;
        for (int k = 1; k <= NCH; k++)
            if (e_ch < 0 && vld[(m_rr + k) % NCH]) e_ch = (m_rr + k) % NCH;
        m_rr = e_ch;
        sym  = a[2*e_ch +: 2];
        ent  = m_tbl[{m_ctx[e_ch], sym}];
        e_out  = ent[2:0];
        e_next = ent[5:3];
        m_ctx[e_ch] = e_next;
        for (int i = 0; i < NCH; i++) if (clr[i]) m_ctx[i] = 3'd0;
        exp_rdy = '0;
        exp_rdy[e_ch] = 1'b1;
    endtask

    // Idle-time table write (call at a negedge with the DUT idle).
    task automatic cfg_write(input logic [4:0] addr, input logic [5:0] dat);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = dat;
        @(negedge clk);
        cfg_we = 1'b0;
        m_tbl[addr] = dat;
    endtask

    task automatic clr_pulse(input logic [NCH-1:0] clr);
        ctx_clr = clr;
        @(negedge clk);
        ctx_clr = '0;
        for (int i = 0; i < NCH; i++) if (clr[i]) m_ctx[i] = 3'd0;
    endtask

    // Drive one request transaction from an idle negedge and record what the DUT shows.
    task automatic step(input logic [NCH-1:0] vld, input logic [2*NCH-1:0] a, input int stall,
                        input logic [NCH-1:0] clr, input logic cw, input logic [4:0] caddr, input logic [5:0] cdat);
        req_valid = vld; req_a = a; out_ready = (stall == 0);
        #1 o_rdy = req_ready;
        @(negedge clk);
        o_busy1 = cfg_busy; o_vld1 = out_valid; o_rdy1 = req_ready; ctx_clr = clr;
        @(negedge clk);
        ctx_clr = '0;
        o_vld2 = out_valid; o_ch = out_ch; o_saida = out_saida; o_state = out_state; o_busy_out = cfg_busy;
        cfg_we = cw; cfg_addr = caddr; cfg_data = cdat;
        o_stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            if (!out_valid || out_ch !== o_ch || out_saida !== o_saida || out_state !== o_state || req_ready !== '0)
                o_stable = 1'b0;
            if (k == stall - 1) out_ready = 1'b1;
        end
        @(negedge clk);
        cfg_we = 1'b0; req_valid = '0;
        o_busy3 = cfg_busy; o_vld3 = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; req_a = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_ch !== '0) begin n_bad++; $display("FAIL rst_out_ch got %0d exp 0", out_ch); end
        n_cmp++; if (out_saida !== 3'd0) begin n_bad++; $display("FAIL rst_out_saida got %0d exp 0", out_saida); end
        n_cmp++; if (out_state !== 3'd0) begin n_bad++; $display("FAIL rst_out_state got %0d exp 0", out_state); end
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_busy got %b exp 0", cfg_busy); end
        req_valid = '0;
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    task automatic test_program_default();
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL prog_busy got %b exp 0", cfg_busy); end
        for (int i = 0; i < 32; i++) cfg_write(5'(i), spec_default(i));
    endtask

    task automatic test_basic();
        m_txn(2'b01, 4'b0001, '0);
        step(2'b01, 4'b0001, 0, '0, 1'b0, '0, '0);
        n_cmp++; if (o_rdy !== 2'b01) begin n_bad++; $display("FAIL basic_rdy got %b exp 01", o_rdy); end
        n_cmp++; if (o_busy1 !== 1'b1 || o_vld1 !== 1'b0) begin n_bad++; $display("FAIL basic_t1 got busy=%b vld=%b exp busy=1 vld=0", o_busy1, o_vld1); end
        n_cmp++; if (o_vld2 !== 1'b1) begin n_bad++; $display("FAIL basic_t2_valid got %b exp 1", o_vld2); end
        n_cmp++; if (o_ch !== 1'b0) begin n_bad++; $display("FAIL basic_ch got %0d exp 0", o_ch); end
        n_cmp++; if (o_saida !== 3'd1) begin n_bad++; $display("FAIL basic_saida got %0d exp 1", o_saida); end
        n_cmp++; if (o_state !== 3'd2) begin n_bad++; $display("FAIL basic_state got %0d exp 2", o_state); end
        n_cmp++; if (o_busy3 !== 1'b0 || o_vld3 !== 1'b0) begin n_bad++; $display("FAIL basic_t3 got busy=%b vld=%b exp 0 0", o_busy3, o_vld3); end
        // ch0 continues from state 2 with a=2 -> entry 10
        m_txn(2'b01, 4'b0010, '0);
        step(2'b01, 4'b0010, 0, '0, 1'b0, '0, '0);
        n_cmp++; if (o_saida !== 3'd2 || o_state !== 3'd4) begin n_bad++; $display("FAIL ch0_step2 got saida=%0d state=%0d exp 2 4", o_saida, o_state); end
        // ch1 still in state 0
        m_txn(2'b10, 4'b0100, '0);
        step(2'b10, 4'b0100, 0, '0, 1'b0, '0, '0);
        n_cmp++; if (o_ch !== 1'b1 || o_saida !== 3'd1 || o_state !== 3'd2) begin n_bad++; $display("FAIL ch1_indep got ch=%0d saida=%0d state=%0d exp 1 1 2", o_ch, o_saida, o_state); end
    endtask

    task automatic test_alternate();
        logic [3:0] a;
        for (int k = 0; k < 6; k++) begin
            a = 4'($urandom);
            m_txn(2'b11, a, '0);
            step(2'b11, a, 0, '0, 1'b0, '0, '0);
            n_cmp++; if (o_ch !== 1'((k % 2))) begin n_bad++; $display("FAIL alt_order k=%0d got ch %0d exp %0d", k, o_ch, k % 2); end
            n_cmp++; if (o_rdy !== exp_rdy || o_saida !== e_out || o_state !== e_next) begin n_bad++;
                $display("FAIL alt_result k=%0d got rdy=%b saida=%0d state=%0d exp %b %0d %0d", k, o_rdy, o_saida, o_state, exp_rdy, e_out, e_next); end
        end
    endtask

    task automatic test_stall();
        logic [3:0] a;
        a = 4'($urandom);
        m_txn(2'b11, a, '0);
        step(2'b11, a, 5, '0, 1'b0, '0, '0);
        n_cmp++; if (o_stable !== 1'b1) begin n_bad++; $display("FAIL stall_stable got %b exp 1", o_stable); end
        n_cmp++; if (o_ch !== 1'(e_ch) || o_saida !== e_out || o_state !== e_next) begin n_bad++;
            $display("FAIL stall_fields got ch=%0d saida=%0d state=%0d exp %0d %0d %0d", o_ch, o_saida, o_state, e_ch, e_out, e_next); end
        n_cmp++; if (o_vld3 !== 1'b0 || o_busy3 !== 1'b0) begin n_bad++; $display("FAIL stall_release got vld=%b busy=%b exp 0 0", o_vld3, o_busy3); end
    endtask

    task automatic test_cfg();
        clr_pulse(2'b01);
        cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 6'h3f; req_valid = 2'b01; req_a = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL cfg_wins_rdy got %b exp 00", req_ready); end
        @(negedge clk);
        cfg_we = 1'b0; req_valid = '0;
        m_tbl[1] = 6'h3f;
        n_cmp++; if (cfg_busy !== 1'b0) begin n_bad++; $display("FAIL cfg_wins_nogrant got busy %b exp 0", cfg_busy); end
        // Write to entry 1 attempted while busy must be dropped.
        m_txn(2'b01, 4'b0001, '0);
        step(2'b01, 4'b0001, 1, '0, 1'b1, 5'd1, 6'h00);
        n_cmp++; if (o_saida !== 3'd7 || o_state !== 3'd7) begin n_bad++; $display("FAIL cfg_new_entry got saida=%0d state=%0d exp 7 7", o_saida, o_state); end
        n_cmp++; if (o_busy_out !== 1'b1) begin n_bad++; $display("FAIL cfg_busy_out got %b exp 1", o_busy_out); end
        clr_pulse(2'b01);
        m_txn(2'b01, 4'b0001, '0);
        step(2'b01, 4'b0001, 0, '0, 1'b0, '0, '0);
        n_cmp++; if (o_saida !== 3'd7 || o_state !== 3'd7) begin n_bad++; $display("FAIL cfg_busy_dropped got saida=%0d state=%0d exp 7 7", o_saida, o_state); end
    endtask

    task automatic test_ctx_clr();
        clr_pulse(2'b01);
        m_txn(2'b01, 4'b0001, 2'b01);
        step(2'b01, 4'b0001, 0, 2'b01, 1'b0, '0, '0);
        n_cmp++; if (o_state !== 3'd7 || o_saida !== 3'd7) begin n_bad++; $display("FAIL clr_same_report got saida=%0d state=%0d exp 7 7", o_saida, o_state); end
        m_txn(2'b01, 4'b0001, '0);
        step(2'b01, 4'b0001, 0, '0, 1'b0, '0, '0);
        n_cmp++; if (o_state !== 3'd7 || o_saida !== 3'd7) begin n_bad++; $display("FAIL clr_same_ctx got saida=%0d state=%0d exp 7 7", o_saida, o_state); end
        // ch0 now in state 7; clear ch1 during ch0's step
        m_txn(2'b01, 4'b0001, 2'b10);
        step(2'b01, 4'b0001, 0, 2'b10, 1'b0, '0, '0);
        n_cmp++; if (o_ch !== 1'b0 || o_state !== 3'd0 || o_saida !== 3'd0) begin n_bad++; $display("FAIL clr_other_inflight got ch=%0d saida=%0d state=%0d exp 0 0 0", o_ch, o_saida, o_state); end
        m_txn(2'b10, 4'b0100, '0);
        step(2'b10, 4'b0100, 0, '0, 1'b0, '0, '0);
        n_cmp++; if (o_ch !== 1'b1 || o_state !== 3'd7 || o_saida !== 3'd7) begin n_bad++; $display("FAIL clr_other_ctx got ch=%0d saida=%0d state=%0d exp 1 7 7", o_ch, o_saida, o_state); end
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b10; req_a = 4'b0100; out_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_valid got %b exp 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || cfg_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_drop got vld=%b busy=%b exp 0 0", out_valid, cfg_busy); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        m_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            m_txn(2'b11, 4'b0101, '0);
            step(2'b11, 4'b0101, 0, '0, 1'b0, '0, '0);
            n_cmp++; if (o_ch !== 1'(k) || o_saida !== e_out || o_state !== e_next) begin n_bad++;
                $display("FAIL rstmid_ctx k=%0d got ch=%0d saida=%0d state=%0d exp %0d %0d %0d", k, o_ch, o_saida, o_state, k, e_out, e_next); end
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0]   vld, clr;
        logic [2*NCH-1:0] a;
        int               stall;
        for (int i = 0; i < 32; i++) cfg_write(5'(i), 6'($urandom));
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) cfg_write(5'($urandom), 6'($urandom));
            vld   = 2'($urandom_range(1, 3));
            a     = 4'($urandom);
            stall = $urandom_range(0, 2);
            clr   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : '0;
            m_txn(vld, a, clr);
            step(vld, a, stall, clr, 1'b0, '0, '0);
            n_cmp++; if (o_rdy !== exp_rdy || o_ch !== 1'(e_ch)) begin n_bad++;
                $display("FAIL rand_grant it=%0d got rdy=%b ch=%0d exp %b %0d", it, o_rdy, o_ch, exp_rdy, e_ch); end
            n_cmp++; if (o_vld2 !== 1'b1 || o_saida !== e_out || o_state !== e_next) begin n_bad++;
                $display("FAIL rand_result it=%0d got vld=%b saida=%0d state=%0d exp 1 %0d %0d", it, o_vld2, o_saida, o_state, e_out, e_next); end
            n_cmp++; if (o_vld3 !== 1'b0) begin n_bad++; $display("FAIL rand_drain it=%0d got %b exp 0", it, o_vld3); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_tbl[i] = 6'h00;
        test_reset();
        test_program_default();
        test_basic();
        test_alternate();
        test_stall();
        test_cfg();
        test_ctx_clr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
